uart_tx_fifo_param: RTL

//  Parametrised UART transmitter: FIFO buffer in front of a framing FSM, with an internal baud divider.

---
 rtl/uart_tx_fifo_param.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with a write FIFO, internal baud divider and configurable framing.
// Each frame latches its baud divisor, parity mode and stop-bit count when its word leaves the FIFO.
module uart_tx_fifo_param #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign s_ready    = !fifo_full;
  assign fifo_count = count;
  assign push       = s_valid && !fifo_full && !rst;
  assign head       = mem[rd_ptr];

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // ---------------- Framing FSM ----------------
  state_t               state, state_n;
  logic [DIV_W-1:0]     baud_cnt, baud_n, div_q, div_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic                 par_bit, par_n;
  logic [1:0]           pmode_q, pm_n;
  logic                 stop2_q, st2_n;
  logic                 stop_cnt, stopc_n;
  logic                 txd_n, done_n, load, bit_end;

  assign bit_end = (baud_cnt == div_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    baud_n  = (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    par_n   = par_bit;
    div_n   = div_q;
    pm_n    = pmode_q;
    st2_n   = stop2_q;
    stopc_n = stop_cnt;
    txd_n   = txd;
    done_n  = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;

    if (!tx_en) begin
      state_n = IDLE;
      baud_n  = '0;
      txd_n   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          txd_n = 1'b1;
          if (!fifo_empty) load = 1'b1;
        end
        START: if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
          txd_n   = shreg[0];
        end
        DATA: if (bit_end) begin
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            stopc_n = 1'b0;
            if (pmode_q != 2'b00) begin
              state_n = PARITY;
              txd_n   = par_bit;
            end else begin
              state_n = STOP;
              txd_n   = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
            sh_n  = shreg >> 1;
            txd_n = shreg[1];
          end
        end
        PARITY: if (bit_end) begin
          state_n = STOP;
          stopc_n = 1'b0;
          txd_n   = 1'b1;
        end
        STOP: if (bit_end) begin
          if (stop2_q && !stop_cnt) begin
            stopc_n = 1'b1;
          end else begin
            done_n = 1'b1;
            // Back-to-back frames: the next start bit begins on the edge ending this stop bit.
            if (!fifo_empty) load = 1'b1;
            else begin
              state_n = IDLE;
              txd_n   = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (load) begin
      pop     = 1'b1;
      state_n = START;
      baud_n  = '0;
      txd_n   = 1'b0;
      sh_n    = head;
      div_n   = baud_div;
      pm_n    = parity_mode;
      st2_n   = stop2;
      unique case (parity_mode)
        2'b01:   par_n = ^head;
        2'b10:   par_n = ~^head;
        default: par_n = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      div_q    <= '0;
      pmode_q  <= 2'b00;
      stop2_q  <= 1'b0;
      stop_cnt <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= sh_n;
      par_bit  <= par_n;
      div_q    <= div_n;
      pmode_q  <= pm_n;
      stop2_q  <= st2_n;
      stop_cnt <= stopc_n;
      txd      <= txd_n;
      busy     <= (state_n != IDLE);
      tx_done  <= done_n;
    end
  end

endmodule
